// File: rtl/mdu_iter_pkg.sv
// Shared core definitions for the iterative multiply/divide unit:
// HI/LO operation encodings and FSM state encodings.
package mdu_iter_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mduOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } mduState_e;

  // op[1] selects divide, op[0] selects the unsigned variant
  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic opIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_mul.sv
// Registered signed/unsigned multiplier: product of the inputs presented in
// cycle N appears on prod after STAGES clock edges (combinational if 0).
module mul_pipe
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 isSigned,
  output logic [2*WIDTH-1:0]   prod
);

  logic signed [2*WIDTH-1:0] extA;
  logic signed [2*WIDTH-1:0] extB;
  logic        [2*WIDTH-1:0] full;

  // Extending both operands to 2*WIDTH makes one signed multiply serve both
  // MULT and MULTU; the low 2*WIDTH bits are exact either way.
  assign extA = {{WIDTH{isSigned & a[WIDTH-1]}}, a};
  assign extB = {{WIDTH{isSigned & b[WIDTH-1]}}, b};
  assign full = extA * extB;

  generate
    if (STAGES == 0) begin : g_comb
      assign prod = full;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] stage [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= full;
          for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign prod = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS-style HI/LO multiply/divide unit: pipelined multiply,
// restoring radix-2 divide with a sign-fix cycle, MTHI/MTLO and flush.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);

  mduState_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opA, opB;
  logic [1:0]       opCode;
  logic [WIDTH-1:0] quot, rem, dvs;

  logic [2*WIDTH-1:0] mulProd;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     remShift, diff;
  logic               negQ, negR;
  logic [WIDTH-1:0]   qFix, rFix;

  // Fed straight from the ports so the start cycle counts as the first stage;
  // HI/LO form the last one.
  mul_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (MUL_LAT - 1)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .isSigned (opIsSigned(op)),
    .prod     (mulProd)
  );

  assign absA = (opIsSigned(op) && a[WIDTH-1]) ? -a : a;
  assign absB = (opIsSigned(op) && b[WIDTH-1]) ? -b : b;

  // The partial remainder stays below 2*divisor, so diff's top bit is the borrow.
  assign remShift = {rem, quot[WIDTH-1]};
  assign diff     = remShift - {1'b0, dvs};

  assign negQ = opIsSigned(opCode) & (opA[WIDTH-1] ^ opB[WIDTH-1]);
  assign negR = opIsSigned(opCode) & opA[WIDTH-1];
  assign qFix = negQ ? -quot : quot;
  assign rFix = negR ? -rem : rem;

  // NOTE: every state element below uses non-blocking assignment so all
  // updates in a branch see the pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      opA    <= '0;
      opB    <= '0;
      opCode <= '0;
      quot   <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else begin
      done <= 1'b0;

      if (!busy && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end

      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              opA    <= a;
              opB    <= b;
              opCode <= op;
              cnt    <= '0;
              rem    <= '0;
              quot   <= absA;
              dvs    <= absB;
              if (!opIsDiv(op)) begin
                if (MUL_LAT == 1) begin
                  {hi, lo} <= mulProd;
                  done     <= 1'b1;
                end else begin
                  state <= MUL;
                  busy  <= 1'b1;
                end
              end else if (b == '0) begin
                state <= FIX;
                busy  <= 1'b1;
              end else begin
                state <= DIV;
                busy  <= 1'b1;
              end
            end
          end

          MUL: begin
            if (cnt == MUL_LAST) begin
              {hi, lo} <= mulProd;
              done     <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          DIV: begin
            if (diff[WIDTH]) begin
              rem  <= remShift[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b0};
            end else begin
              rem  <= diff[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == DIV_LAST) state <= FIX;
          end

          FIX: begin
            if (opIsDiv(opCode)) begin
              if (opB == '0) begin
                hi <= opA;
                lo <= '1;
              end else begin
                hi <= rFix;
                lo <= qFix;
              end
            end
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, randomized ops
// against an arithmetic reference model, and cancel/reset/hazard sequences.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_LAT(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operation's meaning, returns {hi, lo}.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sp;
    int     sx, sy;
    logic [W-1:0] q, r;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      2'b01: return {32'h0, x} * {32'h0, y};
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          sx = $signed(x);
          sy = $signed(y);
          if (x == 32'h8000_0000 && sy == -1) return {32'h0, 32'h8000_0000};
          q = sx / sy;
          r = sx % sy;
        end else begin
          q = x / y;
          r = x % y;
        end
        return {r, q};
      end
    endcase
  endfunction

  function automatic int refLat(input logic [1:0] o, input logic [W-1:0] y);
    if (!o[1]) return 2;
    return (y == 0) ? 2 : W + 2;
  endfunction

  // Issue one op in the current cycle, wait (bounded) for done, check
  // latency, result and that busy covered the whole flight.
  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [63:0] expHL, input int expLat, input string name);
    int   n;
    logic busyOk;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start  = 1'b0;
    n      = 1;
    busyOk = 1'b1;
    while (!done && n < 200) begin
      if (!busy) busyOk = 1'b0;
      tick();
      n++;
    end
    check({name, " latency"}, n, expLat);
    check({name, " hilo"}, {hi, lo}, expHL);
    check({name, " busy"}, {busyOk, busy}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic sawDone;
    logic [1:0]   ro;
    logic [W-1:0] rx, ry, loBefore;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3] = '{OP_DIVU,  32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 2};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[5] = '{OP_DIVU,  32'd7,         32'hFFFF_FFFF, 32'd7,         32'd0,         34};
    vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2};
    vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 34};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) tick();
    check("reset state", {busy, done, hi, lo}, '0);
    rst = 1'b0;
    tick();
    check("post-reset idle", {busy, done, hi, lo}, '0);

    // Directed vectors, issued back-to-back in the cycle done is seen.
    for (int i = 0; i < 10; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].lat, $sformatf("vec%0d", i));

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       ry = '0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      runOp(ro, rx, ry, refModel(ro, rx, ry), refLat(ro, ry), $sformatf("rnd%0d", i));
    end
    tick();
    check("done single pulse", done, 1'b0);

    // MTHI while idle, then cancel a DIV at T+10.
    hi_we = 1'b1; wdata = 32'd5;
    tick();
    hi_we = 1'b0;
    check("mthi idle", hi, 32'd5);
    op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    sawDone = 1'b0;
    repeat (9) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy low", busy, 1'b0);
    repeat (40) begin
      if (done) sawDone = 1'b1;
      tick();
    end
    check("cancel no done", sawDone, 1'b0);
    check("cancel hi kept", hi, 32'd5);

    // Cancel in the completion cycle of a multiply wins over the result.
    loBefore = lo;
    op = OP_MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel at completion", {done, busy, hi, lo}, {1'b0, 1'b0, 32'd5, loBefore});

    // Cancel beats start in the same cycle.
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel over start", busy, 1'b0);
    sawDone = 1'b0;
    repeat (4) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    check("cancel over start no done", {sawDone, hi, lo}, {1'b0, 32'd5, loBefore});

    // Start and MTLO during a running DIVU are ignored.
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = OP_MULTU; a = 32'd9; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    n = 7;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("ignored start latency", n, 34);
    check("ignored start result", {hi, lo}, {32'd6, 32'd142});
    tick();
    check("no second op", {done, busy}, 2'b00);
    lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    check("mtlo idle", lo, 32'h1234);

    // Asynchronous reset in the middle of a DIV.
    op = OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async reset", {busy, done, hi, lo}, '0);
    tick();
    rst = 1'b0;
    tick();
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 2, "after reset");
    tick();
    check("final done low", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning multiply latency in cycles after start (>=1).
REQ-003 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  launch operation (E-stage issue pulse).
REQ-006 SHALL have port op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port a  in  WIDTH  rs operand (dividend / multiplicand).
REQ-008 SHALL have port b  in  WIDTH  rt operand (divisor / multiplier).
REQ-009 SHALL have port cancel  in  1  flush; abort in-flight operation.
REQ-010 SHALL have port hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-011 SHALL have port wdata  in  WIDTH  MTHI/MTLO data.
REQ-012 SHALL have port busy  out  1  registered; high while operation in flight (hazard unit stalls F/D/E on start|busy).
REQ-013 SHALL have port done  out  1  one-cycle pulse when HI/LO receive a result.
REQ-014 SHALL have port hi, lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-016 SHALL, in IDLE with start=1, latch a, b and op, and go to MUL (op[1]=0) or DIV (op[1]=1) on the next edge.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL, for multiply, load {hi,lo} with the full 2*WIDTH-bit product (signed for MULT, unsigned for MULTU) and assert done exactly MUL_LAT cycles after the start cycle, then return to IDLE.
REQ-019 SHALL, for divide, run a restoring radix-2 loop on magnitudes for exactly WIDTH cycles in DIV, then one cycle in FIX applying signs; done and the HI/LO update occur on the FIX exit edge (start at cycle T -> done at T+WIDTH+2).
REQ-020 SHALL give lo=quotient and hi=remainder; for DIV, quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 SHALL, on divide with b=0, skip DIV, take FIX next cycle, and return lo=all ones, hi=a (done at T+2).
REQ-022 SHALL, for DIV of most-negative by -1, return lo=most-negative, hi=0 without trapping.
REQ-023 SHALL, when cancel=1, force state to IDLE on the next edge, leave hi/lo unchanged, and suppress done; cancel takes priority over start and over completion in the same cycle.
REQ-024 SHALL honour hi_we/lo_we only when busy=0 and start=0; when honoured, hi/lo take wdata on the next edge.
REQ-025 SHALL hold the iteration counter at ceil(log2(WIDTH+1)) bits with no wrap-around before FIX.
REQ-026 SHALL keep done low in every cycle except the completion edge; back-to-back start in the cycle after done is accepted.

Reset
REQ-027 SHALL, on rst=1 (asynchronous), force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and operand latches.
REQ-028 SHALL, on rst mid-operation, discard the result; the first operation after release behaves as from power-up.

Structure
REQ-029 SHALL place the op encodings (MULT/MULTU/DIV/DIVU) and FSM state encodings in the shared core definitions package, not locally.
REQ-030 SHALL contain one sub-module, mul_pipe, a MUL_LAT-stage registered signed/unsigned multiplier; the divide loop is written inline.

Verification
REQ-031 SHALL verify: MULT a=0xFFFFFFFE (-2), b=3 -> at T+2 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for one cycle.
REQ-032 SHALL verify: DIV a=-7, b=2 -> at T+34 lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high T+1..T+33.
REQ-033 SHALL verify: DIVU a=100, b=0 -> at T+2 lo=0xFFFFFFFF, hi=100.
REQ-034 SHALL verify: DIV started with hi=5, cancel at T+10 -> busy low at T+11, done never asserted, hi stays 5.
REQ-035 SHALL verify: start asserted at T+5 during a running DIVU is ignored, and the result is that of the first operation; MTLO 0x1234 while busy is ignored, while MTLO when idle gives lo=0x1234.
REQ-036 SHALL verify: rst asserted mid-DIV between clock edges -> hi=lo=0 and busy=0 immediately; the following MULTU 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=1.
